// File: rtl/branch_unit.sv
// Conditional branch resolver: holds comparator flags, evaluates a branch
// after a valid/ready accept, then drives a PC load and a timed pipeline flush.
module branch_unit #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  equal,
    input  logic                  less,
    input  logic                  flagWrite,
    input  logic                  brValid,
    output logic                  brReady,
    input  logic [2:0]            brCond,
    input  logic [ADDR_WIDTH-1:0] brOffset,
    input  logic [ADDR_WIDTH-1:0] pcIn,
    output logic                  flagZ,
    output logic                  flagN,
    output logic                  taken,
    output logic [ADDR_WIDTH-1:0] pcTarget,
    output logic                  pcLoad,
    output logic                  flush,
    output logic                  brDone
);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        FLUSH
    } state_t;

    state_t                  state;
    logic [2:0]              cond_q;
    logic [ADDR_WIDTH-1:0]   offset_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic                    snap_z;
    logic                    snap_n;
    logic [3:0]              flush_cnt;
    logic                    cond_met;

    always_comb begin
        cond_met = 1'b0;
        case (cond_q)
            3'b000:  cond_met = snap_z;
            3'b001:  cond_met = !snap_z;
            3'b010:  cond_met = snap_n;
            3'b011:  cond_met = !snap_n;
            3'b100:  cond_met = snap_n | snap_z;
            3'b101:  cond_met = !snap_n & !snap_z;
            3'b110:  cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    assign brReady = (state == IDLE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            cond_q    <= '0;
            offset_q  <= '0;
            pc_q      <= '0;
            snap_z    <= 1'b0;
            snap_n    <= 1'b0;
            flush_cnt <= '0;
            flagZ     <= 1'b0;
            flagN     <= 1'b0;
            taken     <= 1'b0;
            pcTarget  <= '0;
            pcLoad    <= 1'b0;
            flush     <= 1'b0;
            brDone    <= 1'b0;
        end else begin
            if (flagWrite) begin
                flagZ <= equal;
                flagN <= less;
            end

            pcLoad <= 1'b0;
            brDone <= 1'b0;

            case (state)
                IDLE: begin
                    if (brValid) begin
                        cond_q   <= brCond;
                        offset_q <= brOffset;
                        pc_q     <= pcIn;
                        // Same-edge flag write is forwarded into the snapshot.
                        snap_z   <= flagWrite ? equal : flagZ;
                        snap_n   <= flagWrite ? less  : flagN;
                        state    <= EVAL;
                    end
                end

                EVAL: begin
                    taken    <= cond_met;
                    pcTarget <= pc_q + offset_q + ADDR_WIDTH'(1);
                    if (cond_met) begin
                        pcLoad    <= 1'b1;
                        flush     <= 1'b1;
                        flush_cnt <= 4'(FLUSH_CYCLES);
                        state     <= FLUSH;
                    end else begin
                        brDone <= 1'b1;
                        state  <= IDLE;
                    end
                end

                FLUSH: begin
                    if (flush_cnt == 4'd1) begin
                        flush  <= 1'b0;
                        brDone <= 1'b1;
                        state  <= IDLE;
                    end
                    flush_cnt <= flush_cnt - 4'd1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: cycle-timeline model plus directed, hand-computed checks.
module tb_branch_unit;

    localparam int unsigned AW = 8;
    localparam int unsigned F  = 2;

    logic          clk = 1'b0;
    logic          rstN;
    logic          equal, less, flagWrite, brValid;
    logic [2:0]    brCond;
    logic [AW-1:0] brOffset, pcIn;
    logic          brReady, flagZ, flagN, taken, pcLoad, flush, brDone;
    logic [AW-1:0] pcTarget;

    branch_unit #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rstN(rstN), .equal(equal), .less(less), .flagWrite(flagWrite),
        .brValid(brValid), .brReady(brReady), .brCond(brCond), .brOffset(brOffset),
        .pcIn(pcIn), .flagZ(flagZ), .flagN(flagN), .taken(taken),
        .pcTarget(pcTarget), .pcLoad(pcLoad), .flush(flush), .brDone(brDone)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Timeline model: expected outputs per cycle index, filled in at accept time.
    int            cyc      = 0;
    int            free_cyc = 0;
    bit            mz = 0, mn = 0;
    bit            tk_old = 0, tk_new = 0;
    int            tk_from = 0;
    bit            e_pl[2048];
    bit            e_fl[2048];
    bit            e_dn[2048];
    bit            e_ev[2048];
    logic [AW-1:0] e_tg[2048];

    function automatic bit cond_true(input logic [2:0] c, input bit z, input bit n);
        case (c)
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return n;
            3'd3:    return !n;
            3'd4:    return n || z;
            3'd5:    return !n && !z;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int n, p, tgt;
        bit sz, sn, t;
        n = cyc + 1;
        p = cyc;
        cyc <= n;
        if (!rstN) begin
            free_cyc <= n;
            mz <= 1'b0; mn <= 1'b0;
            tk_old <= 1'b0; tk_new <= 1'b0; tk_from <= 0;
            for (int i = 0; i < 32; i++) begin
                e_pl[n+i] <= 1'b0; e_fl[n+i] <= 1'b0;
                e_dn[n+i] <= 1'b0; e_ev[n+i] <= 1'b0;
            end
        end else begin
            sz = flagWrite ? equal : mz;
            sn = flagWrite ? less  : mn;
            if (brValid && p >= free_cyc) begin
                t   = cond_true(brCond, sz, sn);
                tgt = (int'(pcIn) + 1 + int'($signed(brOffset))) & ((1 << AW) - 1);
                e_ev[n] <= 1'b1;
                tk_old  <= (n >= tk_from) ? tk_new : tk_old;
                tk_new  <= t;
                tk_from <= n + 1;
                if (t) begin
                    e_pl[n+1] <= 1'b1;
                    e_tg[n+1] <= AW'(tgt);
                    for (int i = 1; i <= int'(F); i++) e_fl[n+i] <= 1'b1;
                    e_dn[n+1+int'(F)] <= 1'b1;
                    free_cyc <= n + 1 + int'(F);
                end else begin
                    e_dn[n+1] <= 1'b1;
                    free_cyc  <= n + 1;
                end
            end
            if (flagWrite) begin
                mz <= equal;
                mn <= less;
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    task automatic model_check();
        if (!rstN) begin
            chk1("rst_ready", brReady, 1'b1);
            chk1("rst_pcload", pcLoad, 1'b0);
            chk1("rst_flush", flush, 1'b0);
            chk1("rst_done", brDone, 1'b0);
            chk1("rst_taken", taken, 1'b0);
            chk8("rst_target", pcTarget, '0);
        end else begin
            chk1("m_flagZ", flagZ, mz);
            chk1("m_flagN", flagN, mn);
            chk1("m_ready", brReady, cyc >= free_cyc);
            chk1("m_pcload", pcLoad, e_pl[cyc]);
            chk1("m_flush", flush, e_fl[cyc]);
            chk1("m_done", brDone, e_dn[cyc]);
            if (e_pl[cyc]) chk8("m_target", pcTarget, e_tg[cyc]);
            if (!e_ev[cyc]) chk1("m_taken", taken, (cyc >= tk_from) ? tk_new : tk_old);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic set_flags(input logic z, input logic n);
        flagWrite = 1'b1; equal = z; less = n;
        step();
        flagWrite = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (brReady) break;
            step();
        end
        chk1("wait_ready", brReady, 1'b1);
    endtask

    task automatic run_branch(input logic [2:0] c, input logic [AW-1:0] pc, input logic [AW-1:0] off,
                              input logic fw, input logic eq, input logic ls,
                              input logic exp_t, input logic [AW-1:0] exp_tgt,
                              input logic eval_fw, input logic rst_in_flush);
        wait_ready();
        brValid = 1'b1; brCond = c; pcIn = pc; brOffset = off;
        flagWrite = fw; equal = eq; less = ls;
        step();
        brValid = 1'b0; flagWrite = 1'b0;
        chk1("eval_ready", brReady, 1'b0);
        chk1("eval_pcload", pcLoad, 1'b0);
        if (eval_fw) begin
            flagWrite = 1'b1; equal = 1'b1; less = 1'b1;
        end
        step();
        flagWrite = 1'b0;
        chk1("res_taken", taken, exp_t);
        if (exp_t) begin
            chk1("t_pcload", pcLoad, 1'b1);
            chk1("t_flush", flush, 1'b1);
            chk8("t_target", pcTarget, exp_tgt);
            chk1("t_done_early", brDone, 1'b0);
            if (rst_in_flush) begin
                rstN = 1'b0;
                #1;
                chk1("ar_flush", flush, 1'b0);
                chk1("ar_pcload", pcLoad, 1'b0);
                chk1("ar_taken", taken, 1'b0);
                chk1("ar_done", brDone, 1'b0);
                step();
                step();
                rstN = 1'b1;
                step();
                chk1("ar_ready", brReady, 1'b1);
                chk1("ar_flagZ", flagZ, 1'b0);
                chk1("ar_flagN", flagN, 1'b0);
                return;
            end
            for (int k = 1; k < int'(F); k++) begin
                step();
                chk1("t_pcload_once", pcLoad, 1'b0);
                chk1("t_flush_hold", flush, 1'b1);
                chk1("t_done_hold", brDone, 1'b0);
            end
            step();
            chk1("t_done", brDone, 1'b1);
            chk1("t_flush_end", flush, 1'b0);
            chk1("t_done_ready", brReady, 1'b1);
        end else begin
            chk1("nt_done", brDone, 1'b1);
            chk1("nt_pcload", pcLoad, 1'b0);
            chk1("nt_flush", flush, 1'b0);
            chk1("nt_ready", brReady, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] tbl [4];
        logic [7:0] row;
        tbl[0] = 8'h6A; tbl[1] = 8'h56; tbl[2] = 8'h59; tbl[3] = 8'h55;

        rstN = 1'b0; equal = 1'b0; less = 1'b0; flagWrite = 1'b0; brValid = 1'b0;
        brCond = '0; brOffset = '0; pcIn = '0;

        fork
            forever begin
                @(negedge clk);
                model_check();
            end
        join_none

        step();
        step();
        chk1("reset_ready", brReady, 1'b1);
        chk1("reset_flagZ", flagZ, 1'b0);
        chk8("reset_target", pcTarget, 8'h00);
        rstN = 1'b1;
        step();

        // Flag latch then BEQ
        set_flags(1'b1, 1'b0);
        run_branch(3'b000, 8'h10, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0);

        // Forwarding on the accept edge (register holds Z=1,N=0)
        set_flags(1'b1, 1'b0);
        run_branch(3'b010, 8'h40, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 8'h43, 1'b0, 1'b0);
        set_flags(1'b1, 1'b0);
        run_branch(3'b011, 8'h40, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h43, 1'b0, 1'b0);

        // Wrap-around and negative offset
        run_branch(3'b110, 8'hFE, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
        run_branch(3'b110, 8'h05, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF6, 1'b0, 1'b0);

        // Condition sweep against the hand-built truth table
        for (int zn = 0; zn < 4; zn++) begin
            set_flags(zn[1], zn[0]);
            row = tbl[zn];
            for (int c = 0; c < 8; c++) begin
                run_branch(c[2:0], 8'h20, 8'(c), 1'b0, 1'b0, 1'b0, row[c], 8'(8'h21 + c),
                           1'b0, 1'b0);
            end
        end

        // Continuous NEVER requests: accepts every 2 cycles
        wait_ready();
        brValid = 1'b1; brCond = 3'b111; pcIn = 8'h00; brOffset = 8'h00;
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("hs_eval_ready", brReady, 1'b0);
            chk1("hs_eval_done", brDone, 1'b0);
            step();
            chk1("hs_ready", brReady, 1'b1);
            chk1("hs_done", brDone, 1'b1);
            chk1("hs_pcload", pcLoad, 1'b0);
        end
        brValid = 1'b0;
        step();

        // Flag write during EVAL must not affect the resolved branch
        set_flags(1'b0, 1'b0);
        run_branch(3'b000, 8'h50, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h52, 1'b1, 1'b0);
        step();

        // Reset during the first flush cycle
        set_flags(1'b1, 1'b1);
        run_branch(3'b110, 8'h30, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Consumes the `equal`/`less` flags produced by the comparator stage and holds them in a condition-flag register.
- Resolves conditional branches from decode through a valid/ready handshake.
- For a taken branch, drives a one-cycle PC load with the computed target and holds a pipeline flush for a fixed number of cycles.
- Sits between the comparator output and the fetch/PC logic.

Parameters:
- ADDR_WIDTH, 8, width of PC and target address.
- FLUSH_CYCLES, 2, number of cycles `flush` is held after a taken branch; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rstN  input  1  asynchronous active-low reset.
- equal  input  1  comparator zero flag (result == 0).
- less  input  1  comparator negative flag (result < 0, signed).
- flagWrite  input  1  when 1, latch equal/less into the flag register at the clock edge.
- brValid  input  1  branch request valid.
- brReady  output  1  unit can accept a request; 1 only in IDLE.
- brCond  input  3  condition code, see Behaviour.
- brOffset  input  ADDR_WIDTH  signed PC-relative offset.
- pcIn  input  ADDR_WIDTH  PC of the branch instruction.
- flagZ  output  1  registered zero flag.
- flagN  output  1  registered negative flag.
- taken  output  1  result of the last resolved branch; held until the next accept.
- pcTarget  output  ADDR_WIDTH  target address; valid while pcLoad=1.
- pcLoad  output  1  one-cycle pulse: load pcTarget into the PC.
- flush  output  1  squash younger instructions.
- brDone  output  1  one-cycle pulse marking branch completion.

Behaviour:
- Reset (async, rstN=0):
  - state=IDLE, so brReady=1.
  - flagZ, flagN, taken, pcLoad, flush and brDone all 0; pcTarget=0.
  - Any in-flight branch is discarded, including mid-FLUSH; flush drops immediately.
- Flag register:
  - On each rising edge with flagWrite=1: flagZ<=equal, flagN<=less.
  - Updates in any state.
  - equal=less=1 is stored as given, not checked.
- Conditions (brCond):
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 010 BLT: N
  - 011 BGE: !N
  - 100 BLE: N|Z
  - 101 BGT: !N&!Z
  - 110 ALWAYS: 1
  - 111 NEVER: 0
- Accept: a request is accepted on the edge where state=IDLE and brValid=1. At that edge:
  - brCond, brOffset and pcIn are captured.
  - A flag snapshot is captured. If flagWrite=1 on the same edge, the snapshot takes equal/less directly (forwarding); otherwise it takes flagZ/flagN.
  - Flag writes after accept do not affect this branch.
- FSM states: IDLE, EVAL, FLUSH.
  - IDLE -> EVAL on accept.
  - EVAL lasts exactly 1 cycle. At its closing edge:
    - taken is registered.
    - pcTarget <= pcIn + 1 + brOffset (brOffset sign-extended), modulo 2^ADDR_WIDTH; wrap-around is silent.
    - If taken: pcLoad<=1, flush<=1, state -> FLUSH, flush counter loaded with FLUSH_CYCLES.
    - If not taken: brDone<=1, state -> IDLE.
  - FLUSH: flush=1 for exactly FLUSH_CYCLES cycles. pcLoad is 1 only in the first FLUSH cycle. On exit, brDone<=1 and state -> IDLE.
- Latency, counted from the accept edge:
  - Not taken: brDone is high in cycle +2.
  - Taken: pcLoad in cycle +2, flush in cycles +2..+1+FLUSH_CYCLES, brDone in cycle +2+FLUSH_CYCLES.
- Back-to-back: brReady=1 in the same cycle brDone=1. A new accept on that cycle's closing edge is legal, giving a 2-cycle branch throughput for not-taken branches.
- brValid while brReady=0 is ignored; the requester must hold its request.
- pcLoad, brDone and flush are never asserted in IDLE except brDone's single completion cycle.

Test Plan:
- Reset mid-FLUSH: ALWAYS branch, assert rstN=0 during flush cycle 1 -> flush, pcLoad, taken and brDone drop to 0 asynchronously; brReady=1 after release; flagZ=flagN=0.
- Flag latch then BEQ: flagWrite=1 with equal=1, less=0; next cycle brValid with brCond=000, pcIn=0x10, brOffset=0x05 -> pcLoad=1 and pcTarget=0x16 at +2; flush high 2 cycles; brDone at +4.
- Forwarding: flagWrite=1 (equal=0, less=1) on the accept edge with BLT while the register holds Z=1, N=0 -> taken=1. Repeat with BGE -> taken=0 and brDone at +2.
- Wrap and negative offset:
  - pcIn=0xFE, brOffset=0x03, ALWAYS -> pcTarget=0x02.
  - pcIn=0x05, brOffset=0xF0 (-16) -> pcTarget=0xF6.
- Condition sweep: all 8 brCond values × all 4 (Z,N) combinations -> taken matches the condition table. NEVER never pulses pcLoad.
- Handshake: hold brValid=1 continuously with NEVER -> accepts spaced exactly 2 cycles apart, brReady=0 in EVAL. A flagWrite during EVAL does not change taken.
